// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: shared types and constants for the program loader.
//   ld_state_t        - loader FSM state encoding
//   LD_HDR_DEFAULT    - default frame header byte
//   LD_TIMEOUT_DEFAULT- default inter-byte idle limit (cycles)
//   word_count()      - maps the LEN byte to a word count (0 means 256)
package prog_loader_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEN   = 3'd1,
        HI    = 3'd2,
        LO    = 3'd3,
        CSUM  = 3'd4,
        ERROR = 3'd5
    } ld_state_t;

    localparam logic [7:0]  LD_HDR_DEFAULT     = 8'hA5;
    localparam int unsigned LD_TIMEOUT_DEFAULT = 50000;

    function automatic logic [8:0] word_count(input logic [7:0] len);
        return (len == 8'd0) ? 9'd256 : {1'b0, len};
    endfunction

endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if: byte-stream input and program-memory write port of the loader.
//   rx_valid / rx_data / rx_ready - incoming byte handshake (byte taken when valid && ready)
//   pm_we / pm_addr / pm_wdata    - program memory write strobe, address and {hi, lo} word
// modport slave  : the loader (consumes bytes, drives the write port)
// modport master : the environment (byte source, memory side)
interface prog_loader_if;

    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        pm_we;
    logic [7:0]  pm_addr;
    logic [15:0] pm_wdata;

    modport slave (
        input  rx_valid,
        input  rx_data,
        output rx_ready,
        output pm_we,
        output pm_addr,
        output pm_wdata
    );

    modport master (
        output rx_valid,
        output rx_data,
        input  rx_ready,
        input  pm_we,
        input  pm_addr,
        input  pm_wdata
    );

endinterface

// File: rtl/prog_loader_timeout.sv
// loader_timeout: inter-byte idle watchdog for the loader.
//   clk, rst_n - clock, asynchronous active-low reset
//   load       - reloads the counter (a byte was accepted)
//   run        - counting enabled (FSM is inside a frame)
//   expired    - high in the cycle that completes TIMEOUT idle cycles
// Down-counter reloaded with TIMEOUT; expiry is flagged on the terminal count of 1
// so that the FSM leaves the frame on the TIMEOUT-th idle clock edge.
// TIMEOUT = 0 disables expiry entirely.
module loader_timeout #(
    parameter int unsigned TIMEOUT = 50000,
    parameter int unsigned TO_W    = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic run,
    output logic expired
);

    localparam logic [TO_W-1:0] TC_LOAD = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0] TC_ONE  = {{(TO_W-1){1'b0}}, 1'b1};
    localparam logic            TO_EN   = (TIMEOUT != 0);

    logic [TO_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= TC_LOAD;
        end else if (load || !run) begin
            cnt <= TC_LOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - TC_ONE;
        end
    end

    assign expired = TO_EN && run && !load && (cnt == TC_ONE);

endmodule

// File: rtl/prog_loader.sv
// prog_loader: writer side of program memory. Receives a framed byte stream
// (HDR, LEN, LEN x {HI, LO}[, CSUM]) and writes 16-bit words into prog_mem
// while holding the CPU core in reset.
//   clk       - clock
//   rst       - asynchronous reset, active-low
//   bus       - prog_loader_if.slave: rx_valid/rx_data/rx_ready in, pm_we/pm_addr/pm_wdata out
//   clr       - one-cycle pulse, leaves ERROR
//   cpu_hold  - keep the core in reset while a frame is in progress or failed
//   done      - sticky: last frame loaded OK
//   error     - sticky: frame failed (until clr)
// Build option: define PROG_LOADER_CSUM_EN to expect a trailing checksum byte.
//
// state | meaning
// IDLE  | waiting for HDR, other bytes discarded
// LEN   | next byte is the word count (0 = 256)
// HI    | next byte is the high byte of a word
// LO    | next byte is the low byte; word written the following cycle
// CSUM  | next byte is the checksum (checksum builds only)
// ERROR | frame failed; bytes discarded until clr
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter logic [7:0]  HDR     = LD_HDR_DEFAULT,
    parameter int unsigned TIMEOUT = LD_TIMEOUT_DEFAULT,
    parameter int unsigned TO_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    prog_loader_if.slave      bus,
    input  logic              clr,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    ld_state_t   state;
    logic [8:0]  words_left;
    logic [7:0]  addr;
    logic [7:0]  hi_byte;
    logic [7:0]  csum;
    logic [7:0]  csum_next;
    logic        accept;
    logic        in_frame;
    logic        to_expire;

    // Writes go to memory without back-pressure, so the input is always open.
    assign bus.rx_ready = 1'b1;
    assign accept       = bus.rx_valid && bus.rx_ready;
    assign in_frame     = (state == LEN) || (state == HI) || (state == LO) || (state == CSUM);
    assign csum_next    = csum + bus.rx_data;

    loader_timeout #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_timeout (
        .clk     (clk),
        .rst_n   (rst),
        .load    (accept),
        .run     (in_frame),
        .expired (to_expire)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            words_left   <= '0;
            addr         <= '0;
            hi_byte      <= '0;
            csum         <= '0;
            bus.pm_we    <= 1'b0;
            bus.pm_addr  <= '0;
            bus.pm_wdata <= '0;
            cpu_hold     <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
        end else begin
            bus.pm_we <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept && (bus.rx_data == HDR)) begin
                        cpu_hold <= 1'b1;
                        done     <= 1'b0;
                        addr     <= '0;
                        csum     <= '0;
                        state    <= LEN;
                    end
                end
                LEN: begin
                    if (accept) begin
                        words_left <= word_count(bus.rx_data);
                        csum       <= bus.rx_data;
                        state      <= HI;
                    end else if (to_expire) begin
                        error <= 1'b1;
                        state <= ERROR;
                    end
                end
                HI: begin
                    if (accept) begin
                        hi_byte <= bus.rx_data;
                        csum    <= csum_next;
                        state   <= LO;
                    end else if (to_expire) begin
                        error <= 1'b1;
                        state <= ERROR;
                    end
                end
                LO: begin
                    if (accept) begin
                        bus.pm_we    <= 1'b1;
                        bus.pm_addr  <= addr;
                        bus.pm_wdata <= {hi_byte, bus.rx_data};
                        addr         <= addr + 8'd1;
                        csum         <= csum_next;
                        words_left   <= words_left - 9'd1;
                        if (words_left == 9'd1) begin
`ifdef PROG_LOADER_CSUM_EN
                            state <= CSUM;
`else
                            // Hold drops together with the last write strobe.
                            cpu_hold <= 1'b0;
                            done     <= 1'b1;
                            state    <= IDLE;
`endif
                        end else begin
                            state <= HI;
                        end
                    end else if (to_expire) begin
                        error <= 1'b1;
                        state <= ERROR;
                    end
                end
                CSUM: begin
                    if (accept) begin
                        // Words are already in memory; only the status reflects the check.
                        if (csum_next == 8'd0) begin
                            cpu_hold <= 1'b0;
                            done     <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            error <= 1'b1;
                            state <= ERROR;
                        end
                    end else if (to_expire) begin
                        error <= 1'b1;
                        state <= ERROR;
                    end
                end
                ERROR: begin
                    // clr wins over any byte arriving in the same cycle.
                    if (clr) begin
                        error    <= 1'b0;
                        cpu_hold <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;
    import prog_loader_pkg::*;

    localparam logic [7:0] HDR = 8'hA5;
    localparam int         TO  = 16;

    logic clk;
    logic rst_n;
    logic clr;
    logic cpu_hold;
    logic done;
    logic error;

    prog_loader_if bus ();

    prog_loader #(
        .HDR     (HDR),
        .TIMEOUT (TO),
        .TO_W    (16)
    ) dut (
        .clk      (clk),
        .rst      (rst_n),
        .bus      (bus.slave),
        .clr      (clr),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  a;
        logic [15:0] d;
    } wr_t;

    typedef struct packed {
        logic [1:0]       n_noise;
        logic [2:0][7:0]  noise;
        logic [7:0]       len;
        logic [3:0][15:0] words;
        logic             corrupt;
        logic             exp_done;
        logic             exp_error;
    } vec_t;

    wr_t  sb[$];
    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [7:0] exp_addr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (rst_n && bus.pm_we === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write",
                         bus.pm_addr, bus.pm_wdata);
            end else begin
                wr_t e;
                e = sb.pop_front();
                if (bus.pm_addr !== e.a || bus.pm_wdata !== e.d) begin
                    n_fail++;
                    $display("FAIL write: got addr 0x%0h data 0x%0h, expected addr 0x%0h data 0x%0h",
                             bus.pm_addr, bus.pm_wdata, e.a, e.d);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w, inout logic [7:0] sum);
        send_byte(w[15:8]);
        sb.push_back('{a: exp_addr, d: w});
        exp_addr = exp_addr + 8'd1;
        send_byte(w[7:0]);
        sum = sum + w[15:8] + w[7:0];
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic send_frame(input vec_t v, input string tag);
        logic [7:0] sum;
        logic [7:0] cs;
        int nw;
        for (int i = 0; i < int'(v.n_noise); i++) send_byte(v.noise[i]);
        check({tag, "_hold_before_hdr"}, 32'(cpu_hold), 32'd0);
        send_byte(HDR);
        exp_addr = 8'd0;
        check({tag, "_hold_after_hdr"}, 32'(cpu_hold), 32'd1);
        send_byte(v.len);
        sum = v.len;
        nw = (v.len == 8'd0) ? 256 : int'(v.len);
        for (int i = 0; i < nw; i++) send_word(v.words[i], sum);
        cs = 8'h00 - sum;
        if (v.corrupt) cs = cs + 8'd1;
`ifdef PROG_LOADER_CSUM_EN
        send_byte(cs);
`endif
        @(negedge clk);
        check({tag, "_done"},     32'(done),     32'(v.exp_done));
        check({tag, "_error"},    32'(error),    32'(v.exp_error));
        check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(v.exp_error));
        check({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
        if (v.exp_error) begin
            pulse_clr();
            check({tag, "_clr_error"}, 32'(error),    32'd0);
            check({tag, "_clr_hold"},  32'(cpu_hold), 32'd0);
        end
    endtask

    initial begin
        logic [7:0] sum;
        logic [7:0] cs;

        vecs.push_back('{n_noise: 2'd0, noise: 24'h0, len: 8'd2,
                         words: {16'h0, 16'h0, 16'hABCD, 16'h1234},
                         corrupt: 1'b0, exp_done: 1'b1, exp_error: 1'b0});
        vecs.push_back('{n_noise: 2'd3, noise: {8'h5A, 8'hFF, 8'h00}, len: 8'd1,
                         words: {16'h0, 16'h0, 16'h0, 16'h0007},
                         corrupt: 1'b0, exp_done: 1'b1, exp_error: 1'b0});
        vecs.push_back('{n_noise: 2'd0, noise: 24'h0, len: 8'd3,
                         words: {16'h0, 16'hFFFF, 16'hA5A5, 16'h0001},
                         corrupt: 1'b0, exp_done: 1'b1, exp_error: 1'b0});
`ifdef PROG_LOADER_CSUM_EN
        vecs.push_back('{n_noise: 2'd0, noise: 24'h0, len: 8'd2,
                         words: {16'h0, 16'h0, 16'hABCD, 16'h1234},
                         corrupt: 1'b1, exp_done: 1'b0, exp_error: 1'b1});
`endif

        rst_n        = 1'b0;
        clr          = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        exp_addr     = 8'h00;

        repeat (2) @(negedge clk);
        check("rst_cpu_hold", 32'(cpu_hold),     32'd0);
        check("rst_done",     32'(done),         32'd0);
        check("rst_error",    32'(error),        32'd0);
        check("rst_rx_ready", 32'(bus.rx_ready), 32'd1);
        check("rst_pm_we",    32'(bus.pm_we),    32'd0);
        check("rst_pm_addr",  32'(bus.pm_addr),  32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            send_frame(vecs[i], $sformatf("vec%0d", i));
            check($sformatf("vec%0d_rx_ready", i), 32'(bus.rx_ready), 32'd1);
        end

        // clr outside ERROR must not disturb the sticky done flag.
        send_frame(vecs[0], "pre_clr");
        pulse_clr();
        check("idle_clr_done",  32'(done),  32'd1);
        check("idle_clr_error", 32'(error), 32'd0);

        // LEN=0: 256 words, last write lands at 0xFF.
        send_byte(HDR);
        exp_addr = 8'd0;
        send_byte(8'h00);
        sum = 8'h00;
        for (int i = 0; i < 256; i++) send_word({8'(i), ~8'(i)}, sum);
        cs = 8'h00 - sum;
`ifdef PROG_LOADER_CSUM_EN
        send_byte(cs);
`endif
        @(negedge clk);
        check("len0_last_addr", 32'(bus.pm_addr), 32'h0000_00FF);
        check("len0_done",      32'(done),         32'd1);
        check("len0_hold",      32'(cpu_hold),     32'd0);
        check("len0_sb_empty",  32'(sb.size()),    32'd0);

        // Timeout: error on exactly the TO-th idle cycle after the last byte.
        send_byte(HDR);
        send_byte(8'h03);
        repeat (TO - 1) @(negedge clk);
        check("to_not_yet", 32'(error), 32'd0);
        @(negedge clk);
        check("to_error", 32'(error),    32'd1);
        check("to_hold",  32'(cpu_hold), 32'd1);
        check("to_done",  32'(done),     32'd0);
        clr          = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = HDR;
        @(negedge clk);
        clr          = 1'b0;
        bus.rx_valid = 1'b0;
        check("to_clr_error", 32'(error),    32'd0);
        check("to_clr_hold",  32'(cpu_hold), 32'd0);
        // If the HDR above had been taken, this frame would be misparsed.
        send_frame(vecs[1], "post_to");

        // Asynchronous reset after HI accepted.
        send_byte(HDR);
        send_byte(8'h02);
        send_byte(8'h12);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_hold",     32'(cpu_hold),     32'd0);
        check("mid_rst_done",     32'(done),         32'd0);
        check("mid_rst_error",    32'(error),        32'd0);
        check("mid_rst_pm_addr",  32'(bus.pm_addr),  32'd0);
        check("mid_rst_pm_wdata", 32'(bus.pm_wdata), 32'd0);
        check("mid_rst_rx_ready", 32'(bus.rx_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_frame(vecs[0], "post_rst");

        repeat (3) @(negedge clk);
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
